pc_redirect_unit: RTL and testbench

- Fetch-side PC generator. It sits directly downstream of branch_comparator: it consumes branch_take, plus the EX-stage jump flags, PC and operands.
- It owns the architectural fetch PC and computes branch/jump targets.
- It raises pipeline flushes and drives instruction-memory requests.
- It traps misaligned targets through a handshake with the CSR unit, then resumes fetch at the trap vector.

---
 rtl/risc_pkg.sv | 29 ++
 rtl/target_gen.sv | 29 ++
 rtl/pc_redirect_unit.sv | 149 ++++++++++++++
 tb/tb_pc_redirect_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// ----------------------------------------------------------------------------
// risc_pkg
// Shared types and constants for the fetch/branch path of the core.
//   pc_state_e           : fetch-PC controller states (BOOT, RUN, TRAP)
//   DEFAULT_RESET_VECTOR : default first fetch address after reset
//   PC_INC               : sequential fetch stride
//   branch_type_e        : funct3 branch encodings decoded by branch_comparator
// ----------------------------------------------------------------------------
package risc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_INC               = 32'd4;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_type_e;

endpackage

// File: rtl/target_gen.sv
// ----------------------------------------------------------------------------
// target_gen
// Combinational branch/jump target generator.
//   i_is_jalr      : select JALR addressing (rs1 + imm, LSB cleared)
//   i_pc           : PC of the EX instruction (base for branch / JAL)
//   i_rs1          : forwarded rs1 value (base for JALR)
//   i_imm          : sign-extended immediate
//   o_target       : computed target, modulo 2^32
//   o_misaligned   : target is not 4-byte aligned
// ----------------------------------------------------------------------------
module target_gen (
    input  logic        i_is_jalr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_imm,
    output logic [31:0] o_target,
    output logic        o_misaligned
);

    logic [31:0] w_base;
    logic [31:0] w_sum;

    assign w_base = i_is_jalr ? i_rs1 : i_pc;
    assign w_sum  = w_base + i_imm;

    assign o_target     = i_is_jalr ? {w_sum[31:1], 1'b0} : w_sum;
    assign o_misaligned = |o_target[1:0];

endmodule

// File: rtl/pc_redirect_unit.sv
// ----------------------------------------------------------------------------
// pc_redirect_unit
// Fetch-side PC generator: owns the fetch PC, redirects on taken branches and
// jumps, flushes the front of the pipe, and traps misaligned targets through
// a handshake with the CSR unit before resuming at the trap vector.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_i             : hold PC, suppress new requests
//   ex_valid_i          : EX instruction is real (not a bubble)
//   branch_take_i       : conditional branch taken (from branch_comparator)
//   ex_is_jal_i/jalr_i  : EX instruction is JAL / JALR
//   ex_pc_i/imm_i/rs1_i : EX operands for target computation
//   imem_req_o/addr_o   : fetch request and address (address is the PC)
//   imem_ready_i        : imem accepts the request this cycle
//   if_pc_o             : PC of the last accepted fetch (into IF/ID)
//   flush_if_id_o/id_ex_o : squash the two younger instructions
//   exc_valid_o/pc_o/tval_o : misaligned-target exception to the CSR unit
//   exc_ack_i           : CSR unit has taken the exception
//   mtvec_i             : trap vector
// ----------------------------------------------------------------------------
module pc_redirect_unit
    import risc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned XLEN         = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        ex_valid_i,
    input  logic        branch_take_i,
    input  logic        ex_is_jal_i,
    input  logic        ex_is_jalr_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_imm_i,
    input  logic [31:0] ex_rs1_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    output logic [31:0] if_pc_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        exc_valid_o,
    output logic [31:0] exc_pc_o,
    output logic [31:0] exc_tval_o,
    input  logic        exc_ack_i,
    input  logic [31:0] mtvec_i
);

    if (XLEN != 32) begin : g_xlen_check
        $error("pc_redirect_unit supports XLEN == 32 only");
    end

    pc_state_e   r_state;
    pc_state_e   w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_if_pc;
    logic [31:0] r_exc_pc;
    logic [31:0] r_exc_tval;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_req;
    logic        w_flush;
    logic        w_exc_load;

    target_gen u_target_gen (
        .i_is_jalr    (ex_is_jalr_i),
        .i_pc         (ex_pc_i),
        .i_rs1        (ex_rs1_i),
        .i_imm        (ex_imm_i),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    // Only meaningful in RUN; BOOT and TRAP ignore the EX stage entirely.
    assign w_redirect = ex_valid_i & (branch_take_i | ex_is_jal_i | ex_is_jalr_i);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req       = 1'b0;
        w_flush     = 1'b0;
        w_exc_load  = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                // Redirect wins over both stall and a pending imem acceptance.
                if (w_redirect) begin
                    w_flush = 1'b1;
                    if (w_misaligned) begin
                        w_exc_load  = 1'b1;
                        w_state_nxt = TRAP;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end else if (!stall_i) begin
                    w_req = 1'b1;
                    if (imem_ready_i) begin
                        w_pc_nxt = r_pc + PC_INC;
                    end
                end
            end
            TRAP: begin
                if (exc_ack_i) begin
                    w_pc_nxt    = mtvec_i;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_if_pc    <= 32'h0;
            r_exc_pc   <= 32'h0;
            r_exc_tval <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_req && imem_ready_i) begin
                r_if_pc <= r_pc;
            end
            if (w_exc_load) begin
                r_exc_pc   <= ex_pc_i;
                r_exc_tval <= w_target;
            end
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_pc;
    assign if_pc_o       = r_if_pc;
    assign flush_if_id_o = w_flush;
    assign flush_id_ex_o = w_flush;
    // Exception stays pending for as long as the controller sits in TRAP.
    assign exc_valid_o   = (r_state == TRAP);
    assign exc_pc_o      = r_exc_pc;
    assign exc_tval_o    = r_exc_tval;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_redirect_unit
// Directed stimulus with a scoreboard: expected fetch addresses, flush events
// and exceptions are queued by the stimulus; a negedge monitor pops and
// compares whenever the DUT presents the corresponding output.
// ----------------------------------------------------------------------------
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        ex_valid_i;
    logic        branch_take_i;
    logic        ex_is_jal_i;
    logic        ex_is_jalr_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_imm_i;
    logic [31:0] ex_rs1_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] if_pc_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        exc_valid_o;
    logic [31:0] exc_pc_o;
    logic [31:0] exc_tval_o;
    logic        exc_ack_i;
    logic [31:0] mtvec_i;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .XLEN         (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .ex_valid_i    (ex_valid_i),
        .branch_take_i (branch_take_i),
        .ex_is_jal_i   (ex_is_jal_i),
        .ex_is_jalr_i  (ex_is_jalr_i),
        .ex_pc_i       (ex_pc_i),
        .ex_imm_i      (ex_imm_i),
        .ex_rs1_i      (ex_rs1_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .if_pc_o       (if_pc_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .exc_valid_o   (exc_valid_o),
        .exc_pc_o      (exc_pc_o),
        .exc_tval_o    (exc_tval_o),
        .exc_ack_i     (exc_ack_i),
        .mtvec_i       (mtvec_i)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tval;
    } exc_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_addr_q[$];
    exc_t        exp_exc_q[$];
    int          flush_pending = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic fail_event(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got event with value 0x%08h, expected no event", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented output event against the queues.
    logic        if_pend = 1'b0;
    logic [31:0] if_exp  = 32'h0;
    logic        exc_prev = 1'b0;

    always @(negedge clk) begin
        if (if_pend) begin
            check("if_pc after accept", if_pc_o, if_exp);
        end
        if_pend <= 1'b0;
        if (imem_req_o && imem_ready_i) begin
            if (exp_addr_q.size() == 0) begin
                fail_event("unexpected fetch", imem_addr_o);
            end else begin
                check("fetch addr", imem_addr_o, exp_addr_q[0]);
                if_exp  <= exp_addr_q[0];
                if_pend <= 1'b1;
                void'(exp_addr_q.pop_front());
            end
        end
        if (flush_if_id_o || flush_id_ex_o) begin
            if (flush_pending == 0) begin
                fail_event("unexpected flush", {30'h0, flush_if_id_o, flush_id_ex_o});
            end else begin
                flush_pending--;
                check("flush_if_id", {31'h0, flush_if_id_o}, 32'h1);
                check("flush_id_ex", {31'h0, flush_id_ex_o}, 32'h1);
                check("req during redirect", {31'h0, imem_req_o}, 32'h0);
            end
        end
        if (exc_valid_o && !exc_prev) begin
            if (exp_exc_q.size() == 0) begin
                fail_event("unexpected exception", exc_tval_o);
            end else begin
                check("exc_pc", exc_pc_o, exp_exc_q[0].pc);
                check("exc_tval", exc_tval_o, exp_exc_q[0].tval);
                void'(exp_exc_q.pop_front());
            end
        end
        exc_prev <= exc_valid_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b1;
        stall_i       = 1'b0;
        ex_valid_i    = 1'b0;
        branch_take_i = 1'b0;
        ex_is_jal_i   = 1'b0;
        ex_is_jalr_i  = 1'b0;
        ex_pc_i       = 32'h0;
        ex_imm_i      = 32'h0;
        ex_rs1_i      = 32'h0;
        imem_ready_i  = 1'b1;
        exc_ack_i     = 1'b0;
        mtvec_i       = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        check("rst imem_req", {31'h0, imem_req_o}, 32'h0);
        check("rst imem_addr", imem_addr_o, 32'h0);
        check("rst if_pc", if_pc_o, 32'h0);
        check("rst flush_if_id", {31'h0, flush_if_id_o}, 32'h0);
        check("rst flush_id_ex", {31'h0, flush_id_ex_o}, 32'h0);
        check("rst exc_valid", {31'h0, exc_valid_o}, 32'h0);
        check("rst exc_pc", exc_pc_o, 32'h0);
        check("rst exc_tval", exc_tval_o, 32'h0);

        // Boot then three back-to-back fetches.
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("boot no req", {31'h0, imem_req_o}, 32'h0);
        tick();
        repeat (3) tick();
        stall_i = 1'b1;

        // Taken branch while stalled: redirect overrides stall.
        ex_valid_i    = 1'b1;
        ex_pc_i       = 32'h100;
        ex_imm_i      = 32'h40;
        branch_take_i = 1'b1;
        flush_pending++;
        tick();
        ex_valid_i    = 1'b0;
        branch_take_i = 1'b0;
        check("branch target", imem_addr_o, 32'h140);
        check("stall no req", {31'h0, imem_req_o}, 32'h0);
        exp_addr_q.push_back(32'h140);
        stall_i = 1'b0;
        tick();
        stall_i = 1'b1;

        // JALR aligned: 0x2001 + 3 = 0x2004.
        ex_valid_i   = 1'b1;
        ex_is_jalr_i = 1'b1;
        ex_pc_i      = 32'h200;
        ex_rs1_i     = 32'h2001;
        ex_imm_i     = 32'h3;
        flush_pending++;
        tick();
        ex_valid_i = 1'b0;
        check("jalr target", imem_addr_o, 32'h2004);
        check("jalr no exc", {31'h0, exc_valid_o}, 32'h0);

        // JALR misaligned: 0x2001 + 1 = 0x2002 (bit 1 set after LSB clear).
        ex_valid_i = 1'b1;
        ex_pc_i    = 32'h300;
        ex_imm_i   = 32'h1;
        flush_pending++;
        exp_exc_q.push_back('{pc: 32'h300, tval: 32'h2002});
        tick();
        ex_valid_i   = 1'b0;
        ex_is_jalr_i = 1'b0;
        check("trap exc_valid", {31'h0, exc_valid_o}, 32'h1);
        check("trap pc hold", imem_addr_o, 32'h2004);

        // In TRAP: no requests, EX ignored, exception held without ack.
        stall_i      = 1'b0;
        imem_ready_i = 1'b1;
        ex_valid_i   = 1'b1;
        ex_is_jal_i  = 1'b1;
        ex_pc_i      = 32'h0;
        ex_imm_i     = 32'h10;
        repeat (5) begin
            @(negedge clk);
            check("trap no req", {31'h0, imem_req_o}, 32'h0);
            check("trap exc held", {31'h0, exc_valid_o}, 32'h1);
            @(posedge clk);
            #1;
        end
        ex_valid_i  = 1'b0;
        ex_is_jal_i = 1'b0;
        exc_ack_i   = 1'b1;
        mtvec_i     = 32'h8000_0000;
        exp_addr_q.push_back(32'h8000_0000);
        tick();
        exc_ack_i = 1'b0;
        check("exc cleared", {31'h0, exc_valid_o}, 32'h0);
        tick();
        stall_i = 1'b1;

        // JAL to 0x20 with ready high: redirect suppresses the acceptance.
        stall_i     = 1'b0;
        ex_valid_i  = 1'b1;
        ex_is_jal_i = 1'b1;
        ex_pc_i     = 32'h10;
        ex_imm_i    = 32'h10;
        flush_pending++;
        tick();
        ex_valid_i  = 1'b0;
        ex_is_jal_i = 1'b0;
        check("jal target", imem_addr_o, 32'h20);

        // Wait states at 0x20.
        imem_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("wait addr hold", imem_addr_o, 32'h20);
            check("wait req high", {31'h0, imem_req_o}, 32'h1);
            @(posedge clk);
            #1;
        end
        exp_addr_q.push_back(32'h20);
        exp_addr_q.push_back(32'h24);
        imem_ready_i = 1'b1;
        tick();
        tick();
        stall_i = 1'b1;

        // Wrap at the top of the address space.
        ex_valid_i  = 1'b1;
        ex_is_jal_i = 1'b1;
        ex_pc_i     = 32'hFFFF_FF00;
        ex_imm_i    = 32'hFC;
        flush_pending++;
        tick();
        ex_valid_i = 1'b0;
        check("wrap target", imem_addr_o, 32'hFFFF_FFFC);
        // Flags stay asserted with ex_valid low: must be ignored.
        branch_take_i = 1'b1;
        ex_imm_i      = 32'h40;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        stall_i = 1'b0;
        repeat (3) tick();
        stall_i       = 1'b1;
        branch_take_i = 1'b0;
        ex_is_jal_i   = 1'b0;
        check("after wrap pc", imem_addr_o, 32'h8);

        // Reset asserted while in TRAP.
        ex_valid_i  = 1'b1;
        ex_is_jal_i = 1'b1;
        ex_pc_i     = 32'h400;
        ex_imm_i    = 32'h2;
        flush_pending++;
        exp_exc_q.push_back('{pc: 32'h400, tval: 32'h402});
        tick();
        ex_valid_i  = 1'b0;
        ex_is_jal_i = 1'b0;
        check("trap2 exc_valid", {31'h0, exc_valid_o}, 32'h1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst2 exc_valid", {31'h0, exc_valid_o}, 32'h0);
        check("rst2 imem_req", {31'h0, imem_req_o}, 32'h0);
        check("rst2 imem_addr", imem_addr_o, 32'h0);
        check("rst2 exc_pc", exc_pc_o, 32'h0);
        check("rst2 exc_tval", exc_tval_o, 32'h0);
        check("rst2 if_pc", if_pc_o, 32'h0);
        stall_i      = 1'b0;
        imem_ready_i = 1'b1;
        exp_addr_q.push_back(32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("boot2 no req", {31'h0, imem_req_o}, 32'h0);
        tick();
        tick();
        stall_i = 1'b1;
        repeat (2) tick();

        check("fetch queue drained", 32'(exp_addr_q.size()), 32'h0);
        check("exc queue drained", 32'(exp_exc_q.size()), 32'h0);
        check("flushes all seen", 32'(flush_pending), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
